// File: rtl/icache_refill_unit.sv
// Refills one instruction-cache line: eight req/ack bus beats, then a held write strobe.
// Minimum latency is 17 cycles from refill_start; stall extends WRITE, and bus waits extend READ.
module icache_refill_unit #(
   parameter int LINE_WORDS = 8,
   parameter int MAX_WAIT   = 255,
   parameter int VLEN       = 32,
   parameter int PLEN       = 32
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        refill_start,
   input  logic [VLEN-6:0]             refill_vaddr,
   input  logic [PLEN-6:0]             refill_paddr,
   input  logic                        refill_abort,
   output logic                        refill_busy,
   output logic                        refill_done,
   output logic                        refill_fault,
   output logic                        mem_req,
   output logic [PLEN-1:0]             mem_addr,
   input  logic                        mem_ack,
   input  logic [31:0]                 mem_rdata,
   input  logic                        mem_err,
   input  logic                        stall,
   output logic [VLEN-6:0]             cache_port_addr,
   output logic [LINE_WORDS-1:0][31:0] cache_port_data,
   output logic                        cache_port_set
);

   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic                        r_mem_req;
   logic                        w_req_nxt;
   logic [BEAT_W-1:0]           r_beat;
   logic [WAIT_W-1:0]           r_wait;
   logic [VLEN-6:0]             r_vaddr;
   logic [PLEN-6:0]             r_paddr;
   logic [LINE_WORDS-1:0][31:0] r_data;
   logic                        w_latch;
   logic                        w_store;
   logic                        w_wait_clr;
   logic                        w_wait_inc;
   logic                        w_wait_hit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_wait_hit = (r_wait == WAIT_LAST);

   always_comb begin
      w_state_nxt    = r_state;
      w_req_nxt      = r_mem_req;
      w_latch        = 1'b0;
      w_store        = 1'b0;
      w_wait_clr     = 1'b0;
      w_wait_inc     = 1'b0;
      refill_done    = 1'b0;
      refill_fault   = 1'b0;
      cache_port_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (refill_start) begin
               w_latch     = 1'b1;
               w_wait_clr  = 1'b1;
               w_state_nxt = READ;
            end
         end
         READ: begin
            // Abort outranks ack, error and timeout; an outstanding beat must still be drained.
            if (refill_abort) begin
               if (!r_mem_req || mem_ack) begin
                  w_req_nxt   = 1'b0;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DRAIN;
               end
            end else if (!r_mem_req) begin
               w_req_nxt  = 1'b1;
               w_wait_clr = 1'b1;
            end else if (mem_ack) begin
               w_req_nxt = 1'b0;
               if (mem_err) begin
                  refill_fault = 1'b1;
                  w_state_nxt  = IDLE;
               end else begin
                  w_store = 1'b1;
                  if (r_beat == LAST_BEAT) begin
                     w_state_nxt = WRITE;
                  end
               end
            end else if (w_wait_hit) begin
               refill_fault = 1'b1;
               w_state_nxt  = DRAIN;
            end else begin
               w_wait_inc = 1'b1;
            end
         end
         WRITE: begin
            if (refill_abort) begin
               w_state_nxt = IDLE;
            end else begin
               cache_port_set = 1'b1;
               if (!stall) begin
                  refill_done = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
         DRAIN: begin
            if (mem_ack) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_req <= 1'b0;
         r_beat    <= '0;
         r_wait    <= '0;
         r_vaddr   <= '0;
         r_paddr   <= '0;
         r_data    <= '0;
      end else begin
         r_mem_req <= w_req_nxt;
         if (w_latch) begin
            r_vaddr <= refill_vaddr;
            r_paddr <= refill_paddr;
            r_beat  <= '0;
         end else if (w_store) begin
            r_data[r_beat] <= mem_rdata;
            r_beat         <= r_beat + 1'b1;
         end
         if (w_wait_clr) begin
            r_wait <= '0;
         end else if (w_wait_inc) begin
            r_wait <= r_wait + 1'b1;
         end
      end
   end

   assign refill_busy     = (r_state != IDLE);
   assign mem_req         = r_mem_req;
   assign mem_addr        = {r_paddr, r_beat, 2'b00};
   assign cache_port_addr = r_vaddr;
   assign cache_port_data = r_data;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Randomized refills against an event-timing model: beat start, fault, done and end cycles
// are computed arithmetically from per-beat bus waits, error/abort/stall choices.
module tb_icache_refill_unit;

   localparam int MAX_W = 4;

   logic              clock;
   logic              reset_n;
   logic              refill_start;
   logic [26:0]       refill_vaddr;
   logic [26:0]       refill_paddr;
   logic              refill_abort;
   logic              refill_busy;
   logic              refill_done;
   logic              refill_fault;
   logic              mem_req;
   logic [31:0]       mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   logic              mem_err;
   logic              stall;
   logic [26:0]       cache_port_addr;
   logic [7:0][31:0]  cache_port_data;
   logic              cache_port_set;

   int n_checks = 0;
   int n_fail   = 0;

   int          tw[8];
   logic [31:0] twd[8];
   int          t_err, t_stall, t_abort, t_rst;
   int          g_done_c, g_fault_c, g_end_c, g_sets;

   icache_refill_unit #(.LINE_WORDS(8), .MAX_WAIT(MAX_W), .VLEN(32), .PLEN(32)) dut (
      .clock(clock), .reset_n(reset_n),
      .refill_start(refill_start), .refill_vaddr(refill_vaddr), .refill_paddr(refill_paddr),
      .refill_abort(refill_abort), .refill_busy(refill_busy), .refill_done(refill_done),
      .refill_fault(refill_fault), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .mem_err(mem_err), .stall(stall),
      .cache_port_addr(cache_port_addr), .cache_port_data(cache_port_data),
      .cache_port_set(cache_port_set)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_busy"}, refill_busy, 0);
      chk({tag, "_done"}, refill_done, 0);
      chk({tag, "_fault"}, refill_fault, 0);
      chk({tag, "_set"}, cache_port_set, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_cp_addr"}, cache_port_addr, 0);
      for (int i = 0; i < 8; i++) chk({tag, "_cp_data"}, cache_port_data[i], 0);
   endtask

   task automatic run_refill(input logic [26:0] pa, input logic [26:0] va);
      int  exp_start[8];
      int  exp_end, exp_done, exp_fault, exp_sets, t, s_k, ack_k, w_st;
      bit  stopped;
      int  cyc, req_cnt, beat, sets, n_done, n_fault, done_c, fault_c, end_c;
      logic [31:0] ea;
      // Timing model: each beat costs one idle gap cycle plus (wait+1) request cycles.
      t = 2; stopped = 0; exp_done = -1; exp_fault = -1; exp_sets = 0; exp_end = -1;
      for (int k = 0; k < 8; k++) exp_start[k] = -1;
      for (int k = 0; k < 8; k++) begin
         if (!stopped) begin
            s_k = t; ack_k = s_k + tw[k];
            if (t_abort == s_k - 1) begin
               exp_end = s_k; stopped = 1;
            end else begin
               exp_start[k] = s_k;
               if (t_abort >= s_k && t_abort <= ack_k && (tw[k] < MAX_W || t_abort <= s_k + MAX_W - 1)) begin
                  exp_end = ack_k + 1; stopped = 1;
               end else if (tw[k] >= MAX_W) begin
                  exp_fault = s_k + MAX_W - 1; exp_end = ack_k + 1; stopped = 1;
               end else if (k == t_err) begin
                  exp_fault = ack_k; exp_end = ack_k + 1; stopped = 1;
               end else begin
                  t = ack_k + 2;
               end
            end
         end
      end
      if (!stopped) begin
         w_st = t - 1;
         if (t_abort >= w_st && t_abort <= w_st + t_stall) begin
            exp_sets = t_abort - w_st; exp_end = t_abort + 1;
         end else begin
            exp_sets = t_stall + 1; exp_done = w_st + t_stall; exp_end = exp_done + 1;
         end
      end

      @(negedge clock);
      refill_start = 1'b1; refill_paddr = pa; refill_vaddr = va;
      refill_abort = 1'b0; mem_ack = 1'b0; mem_err = 1'b0; stall = 1'b0;
      cyc = 0; req_cnt = 0; beat = 0; sets = 0; n_done = 0; n_fault = 0;
      done_c = -1; fault_c = -1; end_c = -1;
      #1 chk("start_idle_busy", refill_busy, 0);
      while (end_c < 0 && cyc < 400) begin
         @(negedge clock);
         cyc++;
         refill_start = (cyc < exp_end) && ($urandom_range(0, 7) == 0);
         if (refill_start) begin
            refill_paddr = 27'($urandom); refill_vaddr = 27'($urandom);
         end
         refill_abort = (cyc == t_abort);
         stall = (sets < t_stall);
         mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
         if (cyc == t_rst) begin
            reset_n = 1'b0; refill_start = 1'b0; refill_abort = 1'b0;
            #1 chk_all_zero("midrst");
            @(negedge clock);
            reset_n = 1'b1;
            return;
         end
         if (mem_req) begin
            if (beat > 7) begin
               chk("extra_req", 1, 0);
            end else begin
               if (req_cnt == 0) chk("beat_start", cyc, exp_start[beat]);
               ea = (32'(pa) << 5) + 32'(beat * 4);
               chk("mem_addr", mem_addr, ea);
               req_cnt++;
               if (req_cnt == tw[beat] + 1) begin
                  mem_ack = 1'b1; mem_rdata = twd[beat]; mem_err = (beat == t_err);
                  req_cnt = 0;
                  if (!mem_err) beat++;
               end
            end
         end else begin
            req_cnt = 0;
         end
         #1;
         if (cache_port_set) begin
            sets++;
            chk("set_addr", cache_port_addr, va);
            for (int i = 0; i < 8; i++) chk("set_word", cache_port_data[i], twd[i]);
         end
         if (refill_done) begin n_done++; done_c = cyc; end
         if (refill_fault) begin n_fault++; fault_c = cyc; end
         if (!refill_busy) end_c = cyc;
      end
      refill_start = 1'b0; refill_abort = 1'b0; mem_ack = 1'b0; mem_err = 1'b0; stall = 1'b0;
      chk("end_cycle", end_c, exp_end);
      chk("done_cnt", n_done, (exp_done >= 0) ? 1 : 0);
      chk("done_cycle", done_c, exp_done);
      chk("fault_cnt", n_fault, (exp_fault >= 0) ? 1 : 0);
      chk("fault_cycle", fault_c, exp_fault);
      chk("set_cnt", sets, exp_sets);
      g_done_c = done_c; g_fault_c = fault_c; g_end_c = end_c; g_sets = sets;
   endtask

   task automatic clear_plan();
      for (int i = 0; i < 8; i++) begin
         tw[i] = 0;
         twd[i] = 32'h11111113 * 32'(i + 1);
      end
      t_err = -1; t_stall = 0; t_abort = -1; t_rst = -1;
   endtask

   initial begin
      reset_n = 1'b0; refill_start = 1'b0; refill_vaddr = '0; refill_paddr = '0;
      refill_abort = 1'b0; mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0; stall = 1'b0;
      #1 chk_all_zero("reset");
      repeat (3) @(negedge clock);
      reset_n = 1'b1;

      // Zero-wait line from physical line 0x100: done 17 cycles after start.
      clear_plan();
      run_refill(27'h100, 27'h0ABCDE);
      chk("basic_done_17", g_done_c, 17);

      // Three stalled WRITE cycles hold the strobe for four cycles.
      clear_plan(); t_stall = 3;
      run_refill(27'h100, 27'h0ABCDE);
      chk("stall_sets_4", g_sets, 4);
      chk("stall_done_20", g_done_c, 20);

      // Bus error on beat 3.
      clear_plan(); t_err = 3;
      run_refill(27'h200, 27'h12345);
      chk("err_fault_8", g_fault_c, 8);
      chk("err_no_set", g_sets, 0);

      // Abort while beat 5 is pending; ack comes 4 cycles later.
      clear_plan(); tw[5] = 4; t_abort = 12;
      run_refill(27'h300, 27'h54321);
      chk("abort_pending_end", g_end_c, 17);

      // Timeout on beat 2, late ack after the fault.
      clear_plan(); tw[2] = 6;
      run_refill(27'h400, 27'h1);
      chk("timeout_fault_9", g_fault_c, 9);
      chk("timeout_end_13", g_end_c, 13);

      // Abort during a gap cycle, and abort during a stalled WRITE.
      clear_plan(); t_abort = 3;
      run_refill(27'h500, 27'h2);
      clear_plan(); t_stall = 3; t_abort = 18;
      run_refill(27'h600, 27'h3);

      // Reset while beat 2 is pending, then a normal refill.
      clear_plan(); tw[2] = 3; t_rst = 7;
      run_refill(27'h700, 27'h4);
      clear_plan();
      run_refill(27'h100, 27'h5);
      chk("post_reset_done_17", g_done_c, 17);

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 8; i++) begin
            tw[i]  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            twd[i] = $urandom;
         end
         t_err   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
         t_stall = int'($urandom_range(0, 3));
         t_abort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 45)) : -1;
         t_rst   = -1;
         run_refill(27'($urandom), 27'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
